shift_rotate_pipe: RTL and testbench
====================================

# shift_rotate_pipe

Parametrised, pipelined shift/rotate unit for the datapath ALU, replacing the single-mode combinational right-rotator. It accepts one operation per cycle over a valid/ready handshake and performs ROR, ROL, SHR, SHL and SRA on a WIDTH-bit operand, one amount bit per pipeline stage. Each result carries carry-out, zero flags and a passthrough tag, so the control unit can match results to instructions.

## Interface
- WIDTH, 32, operand width; power of two, 4..64
- TAG_W, 4, width of the opaque tag carried alongside each operation
- SW, $clog2(WIDTH), derived: shift-amount width and pipeline depth; not overridden
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset (sampled on rising edge of clk)
- in_valid  in  1  operation present on in_* this cycle
- in_ready  out  1  unit accepts the operation this cycle
- in_data  in  WIDTH  operand
- in_amt  in  SW  shift/rotate amount (0..WIDTH-1)
- in_op  in  3  000 ROR, 001 ROL, 010 SHR (logical), 011 SHL, 100 SRA; 101-111 reserved
- in_tag  in  TAG_W  opaque tag, returned unchanged
- out_valid  out  1  result present on out_* this cycle
- out_ready  in  1  consumer accepts the result this cycle
- out_data  out  WIDTH  result
- out_carry  out  1  last bit shifted or rotated out
- out_zero  out  1  out_data == 0
- out_tag  out  TAG_W  tag of this result

## Operation
- SW pipeline stages. Stage k (k = 0..SW-1) applies a shift/rotate of 2^k positions when amt bit k is 1, else passes through. Each stage registers data, remaining op/amt, running carry, tag and a valid bit.
- ROR/ROL: the vacated bits are filled from the opposite end. SHR/SHL: fill with 0. SRA: fill with the original in_data[WIDTH-1].
- Carry for amount n > 0:
  - ROR: result[WIDTH-1].
  - ROL: result[0].
  - SHR/SRA: in_data[n-1].
  - SHL: in_data[WIDTH-n].
- Carry for amount 0: 0. Every stage that shifts overwrites the running carry; a stage that does not shift keeps it.
- Amount 0 is a defined passthrough for every op: out_data = in_data, carry 0. The datapath never sees an undefined output or a latch.
- Reserved ops (101-111) behave as amount 0 passthrough with carry 0. They are not errors.
- out_zero is computed from final-stage data and registered with it.
- Global advance = !out_valid || out_ready. When advance is 1, every stage loads from its predecessor, and stage 0 loads from the inputs with valid = in_valid. When advance is 0, every stage holds.
- in_ready = advance. No bubble compaction: internal invalid slots still wait on stalls.
- No reordering: results leave in acceptance order.

## Timing
- Latency: SW cycles from an accepted input (in_valid && in_ready at edge t) to out_valid at edge t+SW-1 (visible after edge t+SW-1), assuming no stall. For WIDTH=32 the latency is 5 cycles.
- Throughput: 1 operation/cycle while out_ready stays 1.
- Backpressure: when out_valid=1 and out_ready=0, in_ready drops to 0 in the same cycle (combinational) and all out_* hold stable until the transfer.
- A transfer happens on any edge with out_valid && out_ready. A new input can enter on the same edge.
- Reset (rst_n=0 at an edge): all stage valid bits clear. The next cycle out_valid=0, out_data=0, out_carry=0, out_zero=0, out_tag=0 and in_ready=1.
- Reset mid-operation discards every in-flight operation with no partial output. Inputs presented during reset are ignored.
- Data and flag outputs change only on edges with advance=1.

## Test plan
- ROR/ROL: 0x80000001 ROR 1 -> 0xC0000000, carry 1, zero 0. 0x80000001 ROL 4 -> 0x00000018, carry 0. Each result appears 5 cycles after acceptance with the tag intact.
- Shifts and flags:
  - 0x80000000 SRA 31 -> 0xFFFFFFFF, carry 0.
  - 0x00000001 SHR 1 -> 0x00000000, carry 1, zero 1.
  - 0xF0000000 SHL 4 -> 0x00000000, carry 1, zero 1.
- Boundaries: amount 0 with every op on 0xDEADBEEF -> 0xDEADBEEF, carry 0. Reserved op 110 with amount 7 -> passthrough, carry 0. ROR 31 of 0x00000001 -> 0x00000002, carry 0.
- Streaming/backpressure: 8 back-to-back ops with tags 0..7, out_ready low for cycles 6-8 -> in_ready low during the stall, outputs held, all 8 results delivered in tag order, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight -> out_valid=0 and all outputs 0 the next cycle. None of the 3 ops ever appear. A new op after reset completes normally in 5 cycles.
- Random reference check: 10k random op/amt/data with random out_ready, compared against a behavioural model -> data, carry, zero and tag all match. Also rerun with WIDTH=8 (latency 3) and WIDTH=64 (latency 6).

Source files
------------

// File: rtl/shift_rotate_pipe.sv
// Pipelined shift/rotate unit: ROR, ROL, SHR, SHL, SRA with carry-out, zero flag and tag.
// Stage k applies a 2^k-position step when amount bit k is set; all stages advance together.
module shift_rotate_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  // One pipeline step of s positions; returns {carry, data}. Reserved ops never shift.
  function automatic logic [WIDTH:0] shift_step(input logic [WIDTH-1:0] d, input logic [2:0] op,
                                                input int unsigned s, input logic c_in,
                                                input logic en);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] t;
    logic             c;
    r = d;
    t = d;
    c = c_in;
    if (en) begin
      case (op)
        OP_ROR: begin r = (d >> s) | (d << (WIDTH - s)); c = r[WIDTH-1]; end
        OP_ROL: begin r = (d << s) | (d >> (WIDTH - s)); c = r[0]; end
        OP_SHR: begin r = d >> s; t = d >> (s - 1); c = t[0]; end
        OP_SHL: begin r = d << s; t = d >> (WIDTH - s); c = t[0]; end
        // The sign bit is preserved by every SRA step, so it always equals the original msb.
        OP_SRA: begin r = WIDTH'($signed(d) >>> s); t = d >> (s - 1); c = t[0]; end
        default: begin r = d; c = c_in; end
      endcase
    end else begin
      r = d;
      c = c_in;
    end
    return {c, r};
  endfunction

  logic [SW-1:0][WIDTH-1:0] data_q, data_d, src_data_s, res_data_s;
  logic [SW-1:0][TAG_W-1:0] tag_q, tag_d, src_tag_s;
  logic [SW-1:0][2:0]       src_op_s;
  logic [SW-1:0][SW-1:0]    src_amt_s;
  logic [SW-2:0][2:0]       op_q, op_d;
  logic [SW-2:0][SW-1:0]    amt_q, amt_d;
  logic [SW-1:0]            carry_q, carry_d, src_carry_s, res_carry_s;
  logic [SW-1:0]            valid_q, valid_d, src_valid_s;
  logic                     zero_q, zero_d, adv_s;
  logic                     unused_amt_s;

  genvar k;
  generate
    for (k = 0; k < SW; k++) begin : g_stage
      if (k == 0) begin : g_first
        assign src_data_s[k]  = in_data;
        assign src_op_s[k]    = in_op;
        assign src_amt_s[k]   = in_amt;
        assign src_carry_s[k] = 1'b0;
        assign src_tag_s[k]   = in_tag;
        assign src_valid_s[k] = in_valid;
      end else begin : g_next
        assign src_data_s[k]  = data_q[k-1];
        assign src_op_s[k]    = op_q[k-1];
        assign src_amt_s[k]   = amt_q[k-1];
        assign src_carry_s[k] = carry_q[k-1];
        assign src_tag_s[k]   = tag_q[k-1];
        assign src_valid_s[k] = valid_q[k-1];
      end
      assign {res_carry_s[k], res_data_s[k]} =
        shift_step(src_data_s[k], src_op_s[k], 1 << k, src_carry_s[k], src_amt_s[k][k]);
    end
  endgenerate

  // Each stage only consumes its own amount bit; the rest ride along unread.
  assign unused_amt_s = ^amt_q;

  // Global advance: every stage loads from its predecessor or every stage holds.
  always_comb begin
    adv_s   = !valid_q[SW-1] || out_ready;
    data_d  = data_q;
    tag_d   = tag_q;
    op_d    = op_q;
    amt_d   = amt_q;
    carry_d = carry_q;
    valid_d = valid_q;
    zero_d  = zero_q;
    if (adv_s) begin
      data_d  = res_data_s;
      tag_d   = src_tag_s;
      op_d    = src_op_s[SW-2:0];
      amt_d   = src_amt_s[SW-2:0];
      carry_d = res_carry_s;
      valid_d = src_valid_s;
      zero_d  = (res_data_s[SW-1] == {WIDTH{1'b0}});
    end else begin
      zero_d  = zero_q;
    end
  end

  // Pipeline registers with synchronous active-low reset clearing everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      tag_q   <= '0;
      op_q    <= '0;
      amt_q   <= '0;
      carry_q <= '0;
      valid_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      op_q    <= op_d;
      amt_q   <= amt_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = adv_s;
  assign out_valid = valid_q[SW-1];
  assign out_data  = data_q[SW-1];
  assign out_carry = carry_q[SW-1];
  assign out_zero  = zero_q;
  assign out_tag   = tag_q[SW-1];

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Self-checking bench for shift_rotate_pipe (WIDTH=32): directed cases, stall, reset, random model.
module tb_shift_rotate_pipe;

  localparam int W  = 32;
  localparam int TW = 4;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, out_valid, out_ready, out_carry, out_zero;
  logic [W-1:0]  in_data, out_data;
  logic [SW-1:0] in_amt;
  logic [2:0]    in_op;
  logic [TW-1:0] in_tag, out_tag;

  always #5 clk = ~clk;

  shift_rotate_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero),
    .out_tag(out_tag)
  );

  typedef struct {
    logic [W-1:0]  data;
    logic          carry;
    logic [TW-1:0] tag;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0, errors = 0, cyc = 0, delivered = 0, accepted = 0;
  bit            use_dir = 1'b0, lat_mode = 1'b0, prev_stall = 1'b0;
  logic [W-1:0]  dir_data, prev_data;
  logic          dir_carry, prev_carry, prev_zero;
  logic [TW-1:0] prev_tag;

  // Reference: whole-amount rotate/shift straight from the operation rules.
  function automatic exp_t model(input logic [W-1:0] d, input int n, input logic [2:0] op);
    exp_t           e;
    logic [2*W-1:0] dd;
    logic [W-1:0]   r, t;
    logic           c;
    r = d;
    c = 1'b0;
    if (n != 0) begin
      case (op)
        3'd0: begin dd = {d, d} >> n; r = dd[W-1:0]; c = r[W-1]; end
        3'd1: begin dd = {d, d} << n; r = dd[2*W-1:W]; c = r[0]; end
        3'd2: begin r = d >> n; t = d >> (n - 1); c = t[0]; end
        3'd3: begin r = d << n; t = d >> (W - n); c = t[0]; end
        3'd4: begin r = $signed(d) >>> n; t = d >> (n - 1); c = t[0]; end
        default: begin r = d; c = 1'b0; end
      endcase
    end
    e.data  = r;
    e.carry = c;
    e.tag   = '0;
    e.cyc   = 0;
    e.lat   = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (out_valid && !out_ready) begin
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      if (prev_stall) begin
        check("hold_data", {32'd0, out_data}, {32'd0, prev_data});
        check("hold_carry", {63'd0, out_carry}, {63'd0, prev_carry});
        check("hold_zero", {63'd0, out_zero}, {63'd0, prev_zero});
        check("hold_tag", {60'd0, out_tag}, {60'd0, prev_tag});
      end
      prev_stall = 1'b1;
      prev_data  = out_data;
      prev_carry = out_carry;
      prev_zero  = out_zero;
      prev_tag   = out_tag;
    end else begin
      prev_stall = 1'b0;
    end
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_output observed tag=0x%0h expected no output", out_tag);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data", {32'd0, out_data}, {32'd0, e.data});
        check("carry", {63'd0, out_carry}, {63'd0, e.carry});
        check("zero", {63'd0, out_zero}, {63'd0, (e.data == 32'd0)});
        check("tag", {60'd0, out_tag}, {60'd0, e.tag});
        if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(SW));
      end
      delivered++;
    end
    if (rst_n && in_valid && in_ready) begin
      if (use_dir) begin
        e.data  = dir_data;
        e.carry = dir_carry;
      end else begin
        e = model(in_data, int'(in_amt), in_op);
      end
      e.tag = in_tag;
      e.cyc = cyc;
      e.lat = lat_mode;
      exp_q.push_back(e);
      accepted++;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input int amt, input logic [2:0] op,
                      input logic [TW-1:0] tag, input logic [W-1:0] xd, input logic xc);
    in_data   = d;
    in_amt    = SW'(amt);
    in_op     = op;
    in_tag    = tag;
    in_valid  = 1'b1;
    use_dir   = 1'b1;
    dir_data  = xd;
    dir_carry = xc;
    step();
    in_valid  = 1'b0;
    use_dir   = 1'b0;
  endtask

  task automatic drain(input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, {63'd0, out_valid}, 64'd0);
    check({name, "_data"}, {32'd0, out_data}, 64'd0);
    check({name, "_carry"}, {63'd0, out_carry}, 64'd0);
    check({name, "_zero"}, {63'd0, out_zero}, 64'd0);
    check({name, "_tag"}, {60'd0, out_tag}, 64'd0);
    check({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    int start, dstart;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_amt = '0; in_op = '0; in_tag = '0;
    step();
    step();
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Directed values with fixed expectations and latency checks.
    lat_mode = 1'b1;
    send(32'h8000_0001, 1, 3'b000, 4'd1, 32'hC000_0000, 1'b1);
    send(32'h8000_0001, 4, 3'b001, 4'd2, 32'h0000_0018, 1'b0);
    send(32'h8000_0000, 31, 3'b100, 4'd3, 32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0001, 1, 3'b010, 4'd4, 32'h0000_0000, 1'b1);
    send(32'hF000_0000, 4, 3'b011, 4'd5, 32'h0000_0000, 1'b1);
    drain(30);
    for (int op = 0; op < 8; op++)
      send(32'hDEAD_BEEF, 0, 3'(op), 4'(op + 6), 32'hDEAD_BEEF, 1'b0);
    drain(30);
    send(32'h1234_5678, 7, 3'b110, 4'd14, 32'h1234_5678, 1'b0);
    send(32'h0000_0001, 31, 3'b000, 4'd15, 32'h0000_0002, 1'b0);
    send(32'h0000_0001, 31, 3'b011, 4'd7, 32'h8000_0000, 1'b0);
    send(32'h8000_0000, 31, 3'b010, 4'd9, 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 31, 3'b001, 4'd10, 32'h4000_0000, 1'b0);
    drain(30);

    // Eight back-to-back operations with out_ready low for cycles 6-8.
    lat_mode = 1'b0;
    start  = accepted;
    dstart = delivered;
    for (int c = 0; c < 40; c++) begin
      in_valid  = (accepted - start) < 8;
      in_tag    = TW'(accepted - start);
      in_data   = $urandom;
      in_amt    = SW'($urandom_range(0, 31));
      in_op     = 3'($urandom_range(0, 4));
      out_ready = !(c >= 6 && c <= 8);
      step();
    end
    in_valid = 1'b0;
    check("stream_delivered", 64'(delivered - dstart), 64'd8);
    drain(10);

    // Reset with three operations in flight; inputs during reset are ignored.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      in_amt   = SW'($urandom_range(1, 31));
      in_op    = 3'($urandom_range(0, 4));
      in_tag   = TW'(i + 1);
      step();
    end
    in_tag = 4'd12;
    rst_n  = 1'b0;
    step();
    exp_q.delete();
    prev_stall = 1'b0;
    check_idle_outputs("midreset");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    lat_mode = 1'b1;
    send(32'h8000_0001, 1, 3'b000, 4'd6, 32'hC000_0000, 1'b1);
    drain(30);

    // Random operations with random backpressure against the reference model.
    lat_mode = 1'b0;
    start = accepted;
    for (int i = 0; i < 40000 && (accepted - start) < 10000; i++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      in_data   = $urandom;
      in_amt    = SW'($urandom_range(0, 31));
      in_op     = 3'($urandom_range(0, 7));
      in_tag    = TW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) in_data = '0;
      step();
    end
    in_valid = 1'b0;
    check("random_count", 64'(accepted - start), 64'd10000);
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
